// File: rtl/qos_pkg.sv
// Shared definitions for the QoS class buffer and the arbiter that drives it.
// Contents:
//   NQ, CLASS_W   - number of traffic classes and the width of a class index
//   qmask_t       - one bit per queue (grant, empty, full vectors)
//   GNT_Q0..Q3    - one-hot grant encodings, bit i selects queue i
//   onehot0()     - true when a mask has at most one bit set
package qos_pkg;

  localparam int NQ      = 4;
  localparam int CLASS_W = 2;

  typedef logic [NQ-1:0] qmask_t;

  localparam qmask_t GNT_Q0 = 4'b0001;
  localparam qmask_t GNT_Q1 = 4'b0010;
  localparam qmask_t GNT_Q2 = 4'b0100;
  localparam qmask_t GNT_Q3 = 4'b1000;

  // Clearing the lowest set bit leaves zero only for a zero or one-hot mask.
  function automatic logic onehot0(input qmask_t m);
    return (m & (m - 1'b1)) == '0;
  endfunction

endpackage

// File: rtl/qos_fifo.sv
// Single synchronous FIFO used once per traffic class.
// Ports:
//   clk, reset_L   - rising-edge clock, asynchronous active-low reset
//   wr_en_i        - write request; ignored when full unless a read frees a slot
//   wr_data_i      - word to write
//   rd_en_i        - read request; ignored when empty
//   rd_data_o      - current head word (combinational view of storage)
//   count_o        - registered occupancy, 0..DEPTH
//   empty_o/full_o - decoded from count_o
module qos_fifo #(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output logic              full_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_wr, do_rd;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == CNT_W'(DEPTH));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  // A read in the same cycle frees the slot a write into a full FIFO needs.
  assign do_rd = rd_en_i && !empty_o;
  assign do_wr = wr_en_i && (!full_o || do_rd);

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (do_wr && !do_rd) count_d = count_q + 1'b1;
    if (!do_wr && do_rd) count_d = count_q - 1'b1;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage has no reset; pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/qos_class_buffer.sv
// Ingress buffer for the PCIe QoS path: four per-class FIFOs selected by a
// 2-bit traffic class, drained by a one-hot grant from the arbiter.
// Ports:
//   clk, reset_L         - rising-edge clock, asynchronous active-low reset
//   enb                  - global enable shared with the arbiter
//   push/push_class/push_data - enqueue request into queue push_class
//   grant                - one-hot pop select (zero = no pop)
//   data_out/valid_out   - registered popped word and its one-cycle strobe
//   empty/full           - per-queue status from registered counts
//   drop_err             - pulse: push dropped on a full queue
//   grant_err            - pulse: grant not one-hot, or aimed at an empty queue
module qos_class_buffer
  import qos_pkg::*;
#(
  parameter  int DATA_W = 8,
  parameter  int DEPTH  = 4,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk,
  input  logic               reset_L,
  input  logic               enb,
  input  logic               push,
  input  logic [CLASS_W-1:0] push_class,
  input  logic [DATA_W-1:0]  push_data,
  input  logic [NQ-1:0]      grant,
  output logic [DATA_W-1:0]  data_out,
  output logic               valid_out,
  output logic [NQ-1:0]      empty,
  output logic [NQ-1:0]      full,
  output logic               drop_err,
  output logic               grant_err
);

  qmask_t            wr_en, rd_en;
  logic [DATA_W-1:0] rd_data [NQ];
  logic [CNT_W-1:0]  count   [NQ];
  logic [DATA_W-1:0] pop_data;
  logic              grant_ok, drop_d, grant_err_d;

  assign grant_ok = onehot0(grant);

  // Empty queues are masked out, so a legal grant on an empty queue pops nothing
  // and a simultaneous push into that queue is never bypassed to the output.
  assign rd_en = (enb && grant_ok) ? (grant & ~empty) : '0;

  always_comb begin
    wr_en = '0;
    if (enb && push) wr_en[push_class] = 1'b1;
  end

  assign drop_d      = enb && push && full[push_class] && !rd_en[push_class];
  assign grant_err_d = enb && (grant != '0) && (!grant_ok || ((grant & empty) != '0));

  for (genvar g = 0; g < NQ; g++) begin : g_q
    qos_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset_L   (reset_L),
      .wr_en_i   (wr_en[g]),
      .wr_data_i (push_data),
      .rd_en_i   (rd_en[g]),
      .rd_data_o (rd_data[g]),
      .count_o   (count[g]),
      .empty_o   (empty[g]),
      .full_o    (full[g])
    );

    a_flags: assert property (@(posedge clk) disable iff (!reset_L)
      (empty[g] == (count[g] == '0)) && (full[g] == (count[g] == CNT_W'(DEPTH))));
  end

  // NOTE: default assigned first so the mux cannot infer a latch.
  always_comb begin
    pop_data = '0;
    for (int i = 0; i < NQ; i++) begin
      if (rd_en[i]) pop_data = rd_data[i];
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      drop_err  <= 1'b0;
      grant_err <= 1'b0;
    end else begin
      valid_out <= |rd_en;
      drop_err  <= drop_d;
      grant_err <= grant_err_d;
      if (|rd_en) data_out <= pop_data;
    end
  end

endmodule

// File: tb/tb_qos_class_buffer.sv
// Self-checking bench for qos_class_buffer: a per-class queue model predicts
// every pop, error pulse and status flag; a negedge monitor compares.
module tb_qos_class_buffer;
  import qos_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_L = 1'b0;
  logic              enb = 1'b0;
  logic              push = 1'b0;
  logic [1:0]        push_class = '0;
  logic [DATA_W-1:0] push_data = '0;
  logic [3:0]        grant = '0;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic [3:0]        empty, full;
  logic              drop_err, grant_err;

  qos_class_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_L(reset_L), .enb(enb), .push(push),
    .push_class(push_class), .push_data(push_data), .grant(grant),
    .data_out(data_out), .valid_out(valid_out), .empty(empty), .full(full),
    .drop_err(drop_err), .grant_err(grant_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mq [4][$];   // contents of each class queue
  logic [DATA_W-1:0] exp_q [$];   // scoreboard of words that must appear on data_out
  logic              exp_valid = 1'b0, exp_drop = 1'b0, exp_gerr = 1'b0;
  logic [DATA_W-1:0] last_data = '0;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) mq[i].delete();
    exp_q.delete();
    exp_valid = 1'b0;
    exp_drop  = 1'b0;
    exp_gerr  = 1'b0;
    last_data = '0;
  endtask

  always @(posedge clk) begin
    bit popped;
    int pidx;
    popped = 1'b0;
    pidx   = -1;
    if (reset_L) begin
      exp_valid = 1'b0;
      exp_drop  = 1'b0;
      exp_gerr  = 1'b0;
      if (enb) begin
        if (grant != 4'b0000) begin
          if ($countones(grant) != 1) exp_gerr = 1'b1;
          else begin
            for (int i = 0; i < 4; i++) if (grant[i]) pidx = i;
            if (mq[pidx].size() == 0) exp_gerr = 1'b1;
            else begin
              exp_q.push_back(mq[pidx].pop_front());
              exp_valid = 1'b1;
              popped    = 1'b1;
            end
          end
        end
        if (push) begin
          if (mq[push_class].size() < DEPTH || (popped && pidx == int'(push_class)))
            mq[push_class].push_back(push_data);
          else
            exp_drop = 1'b1;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [3:0] e_empty, e_full;
    for (int i = 0; i < 4; i++) begin
      e_empty[i] = (mq[i].size() == 0);
      e_full[i]  = (mq[i].size() == DEPTH);
    end
    check("empty", empty, e_empty);
    check("full", full, e_full);
    check("valid_out", valid_out, exp_valid);
    check("drop_err", drop_err, exp_drop);
    check("grant_err", grant_err, exp_gerr);
    if (exp_valid) begin
      if (exp_q.size() == 0) check("scoreboard_underflow", 1, 0);
      else begin
        last_data = exp_q.pop_front();
        check("data_out", data_out, last_data);
      end
    end else begin
      check("data_out_hold", data_out, last_data);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input logic e, input logic p, input logic [1:0] c,
                      input logic [7:0] d, input logic [3:0] g);
    @(negedge clk);
    enb = e; push = p; push_class = c; push_data = d; grant = g;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000);
  endtask

  initial begin
    model_clear();
    repeat (2) @(negedge clk);
    reset_L = 1'b1;
    idle(1);

    // class 2: three pushes then three pops
    step(1, 1, 2'd2, 8'hA1, 4'b0000);
    step(1, 1, 2'd2, 8'hA2, 4'b0000);
    step(1, 1, 2'd2, 8'hA3, 4'b0000);
    for (int i = 0; i < 3; i++) step(1, 0, 2'd0, 8'h00, GNT_Q2);
    idle(2);

    // class 0: fill, overflow, drain
    for (int i = 0; i < 4; i++) step(1, 1, 2'd0, 8'(8'h10 + i), 4'b0000);
    step(1, 1, 2'd0, 8'h14, 4'b0000);
    idle(1);
    for (int i = 0; i < 4; i++) step(1, 0, 2'd0, 8'h00, GNT_Q0);
    idle(2);

    // class 1: full, push and pop together, then drain
    for (int i = 0; i < 4; i++) step(1, 1, 2'd1, 8'(8'h50 + i), 4'b0000);
    step(1, 1, 2'd1, 8'h55, GNT_Q1);
    idle(1);
    for (int i = 0; i < 4; i++) step(1, 0, 2'd0, 8'h00, GNT_Q1);
    idle(2);

    // illegal grants
    step(1, 1, 2'd0, 8'h21, 4'b0000);
    step(1, 1, 2'd1, 8'h22, 4'b0000);
    step(1, 0, 2'd0, 8'h00, 4'b0011);
    step(1, 0, 2'd0, 8'h00, GNT_Q3);
    step(1, 0, 2'd0, 8'h00, GNT_Q0);
    step(1, 0, 2'd0, 8'h00, GNT_Q1);
    // push into empty queue with same-cycle grant: stored, not bypassed
    step(1, 1, 2'd3, 8'h33, GNT_Q3);
    step(1, 0, 2'd0, 8'h00, GNT_Q3);
    idle(2);

    // wrap-around on queue 3 with counter data
    step(1, 1, 2'd3, 8'h80, 4'b0000);
    for (int i = 1; i < 3 * DEPTH; i++) step(1, 1, 2'd3, 8'(8'h80 + i), GNT_Q3);
    step(1, 0, 2'd0, 8'h00, GNT_Q3);
    idle(2);

    // enb low: pushes and grants ignored
    step(1, 1, 2'd0, 8'h61, 4'b0000);
    for (int i = 0; i < 4; i++) step(0, 1, 2'(i), 8'(8'h70 + i), GNT_Q0);
    step(1, 0, 2'd0, 8'h00, GNT_Q0);
    idle(2);

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [3:0] g;
      int r;
      r = $urandom_range(0, 9);
      if (r < 3)      g = 4'b0000;
      else if (r < 9) g = 4'(1 << $urandom_range(0, 3));
      else            g = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 6),
           2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), g);
    end
    idle(2);

    // asynchronous reset mid-drain
    for (int i = 0; i < 3; i++) step(1, 1, 2'(i), 8'(8'hC0 + i), 4'b0000);
    step(1, 1, 2'd0, 8'hC4, 4'b0000);
    step(1, 0, 2'd0, 8'h00, GNT_Q0);
    @(posedge clk);
    #2;
    reset_L = 1'b0;
    model_clear();
    #1;
    check("rst_empty", empty, 4'b1111);
    check("rst_full", full, 4'b0000);
    check("rst_valid", valid_out, 1'b0);
    check("rst_data", data_out, 8'h00);
    check("rst_errs", {drop_err, grant_err}, 2'b00);
    step(1, 0, 2'd0, 8'h00, 4'b0000);
    @(negedge clk);
    reset_L = 1'b1;
    step(1, 0, 2'd0, 8'h00, GNT_Q0);
    step(1, 0, 2'd0, 8'h00, GNT_Q1);
    idle(3);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
